alu_req_arbiter: RTL

//  Shares one ALU_8BIT instance among NUM_REQ requesters.

---
 rtl/alu_arb_pkg.sv | 28 ++
 rtl/alu_req_arbiter_rr.sv | 41 ++++
 rtl/alu_req_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/alu_arb_pkg.sv
// ---------------------------------------------------------------------------
// alu_arb_pkg
//   Shared definitions for the ALU request arbiter: FSM state encoding,
//   ALU opcode values and default operand/opcode widths.
// ---------------------------------------------------------------------------
package alu_arb_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned OP_W_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // ALU opcodes; 9..15 are reserved and make the ALU return 0.
  localparam int unsigned OP_PASS = 0;  // a
  localparam int unsigned OP_ADD  = 1;  // a + b
  localparam int unsigned OP_SUB  = 2;  // a - b
  localparam int unsigned OP_INC  = 3;  // a + 1
  localparam int unsigned OP_DEC  = 4;  // a - 1
  localparam int unsigned OP_OR   = 5;  // a | b
  localparam int unsigned OP_XOR  = 6;  // a ^ b
  localparam int unsigned OP_AND  = 7;  // a & b
  localparam int unsigned OP_NOT  = 8;  // {0, ~a}

endpackage

// File: rtl/alu_req_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin picker. Scans req upward starting at rr_ptr,
//   wrapping at NUM_REQ-1, and reports the first set bit.
// Ports
//   req        in   NUM_REQ  request vector
//   rr_ptr     in   ID_W     highest-priority index this cycle
//   grant      out  NUM_REQ  one-hot grant (zero when req is zero)
//   grant_idx  out  ID_W     index of the granted bit (0 when none)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  int idx;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; otherwise a path that skips it infers a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = 0;
    // Walk from the farthest offset down to offset 0 so the candidate
    // closest to rr_ptr is the one left standing.
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = (int'(rr_ptr) + off) % NUM_REQ;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// ---------------------------------------------------------------------------
// alu_req_arbiter
//   Shares one external 8-bit ALU among NUM_REQ requesters. A round-robin
//   arbiter grants one request in IDLE, the operands are registered onto the
//   ALU ports for one EXEC cycle, and the ALU result is registered and held
//   on the response port (RESP) until accepted. One operation per 3+ cycles.
//
// Optional feature: define ALU_ARB_FLAGS_EN to add rsp_zero / rsp_carry.
//
// Ports
//   clk         in   1               clock, rising edge
//   rst_n       in   1               asynchronous active-low reset
//   req_valid   in   NUM_REQ         per-requester request valid
//   req_ready   out  NUM_REQ         per-requester accept (one-hot or zero)
//   req_a       in   NUM_REQ*DATA_W  operand A, requester i at [i*DATA_W +: DATA_W]
//   req_b       in   NUM_REQ*DATA_W  operand B
//   req_op      in   NUM_REQ*OP_W    opcode
//   alu_a_in    out  DATA_W          to ALU a_in
//   alu_b_in    out  DATA_W          to ALU b_in
//   alu_op      out  OP_W            to ALU op
//   alu_result  in   DATA_W+1        from ALU (combinational)
//   rsp_valid   out  1               response valid
//   rsp_ready   in   1               response accept
//   rsp_result  out  DATA_W+1        registered ALU result
//   rsp_id      out  ID_W            requester that owns rsp_result
//   rsp_zero    out  1               (ALU_ARB_FLAGS_EN) low DATA_W bits zero
//   rsp_carry   out  1               (ALU_ARB_FLAGS_EN) rsp_result[DATA_W]
// ---------------------------------------------------------------------------
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = DATA_W_DEF,
  parameter  int OP_W    = OP_W_DEF,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic [DATA_W-1:0]         alu_a_in,
  output logic [DATA_W-1:0]         alu_b_in,
  output logic [OP_W-1:0]           alu_op,
  input  logic [DATA_W:0]           alu_result,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W:0]           rsp_result,
  output logic [ID_W-1:0]           rsp_id
`ifdef ALU_ARB_FLAGS_EN
  ,
  output logic                      rsp_zero,
  output logic                      rsp_carry
`endif
);

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q;
  logic [ID_W-1:0]     grant_q;     // owner of the operation in flight
  logic [NUM_REQ-1:0]  grant_vec;
  logic [ID_W-1:0]     grant_idx;
  logic                ld_req;      // IDLE -> EXEC: capture operands
  logic                ld_rsp;      // EXEC -> RESP: capture result
  logic                rsp_done;    // RESP handshake completes

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant_vec),
    .grant_idx (grant_idx)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    ld_req    = 1'b0;
    ld_rsp    = 1'b0;
    rsp_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready = grant_vec;
          ld_req    = 1'b1;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        ld_rsp  = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        // rsp_valid is always high in RESP, so rsp_ready alone completes it.
        if (rsp_ready) begin
          rsp_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_in   <= '0;
      alu_b_in   <= '0;
      alu_op     <= '0;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_id     <= '0;
`ifdef ALU_ARB_FLAGS_EN
      rsp_zero   <= 1'b0;
      rsp_carry  <= 1'b0;
`endif
    end else begin
      if (ld_req) begin
        alu_a_in <= req_a[int'(grant_idx)*DATA_W +: DATA_W];
        alu_b_in <= req_b[int'(grant_idx)*DATA_W +: DATA_W];
        alu_op   <= req_op[int'(grant_idx)*OP_W +: OP_W];
        grant_q  <= grant_idx;
      end
      if (ld_rsp) begin
        rsp_valid  <= 1'b1;
        rsp_result <= alu_result;
        rsp_id     <= grant_q;
`ifdef ALU_ARB_FLAGS_EN
        rsp_zero   <= (alu_result[DATA_W-1:0] == '0);
        rsp_carry  <= alu_result[DATA_W];
`endif
      end
      if (rsp_done) begin
        rsp_valid <= 1'b0;
        // Priority moves just past the requester that was served.
        rr_ptr_q  <= (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);
      end
    end
  end

endmodule
